// File: rtl/spi_controller_pkg.sv
// ---------------------------------------------------------------------------
// spi_controller_pkg
//   Definitions shared by the SPI controller, its clock timer and anything
//   that needs to speak the same bus dialect: the controller state
//   encoding, the SPI mode constants for mode 0 and a counter-width helper.
// ---------------------------------------------------------------------------
package spi_controller_pkg;

  // Controller phases. LEAD is the mosi setup time before the first rising
  // edge. HIGH and LOW are the two sclk half-periods. The last LOW also
  // serves as the trail (hold) time before cs is released.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LEAD = 2'b01,
    HIGH = 2'b10,
    LOW  = 2'b11
  } spiState_t;

  // Mode 0: sclk idles low and data is captured on the rising edge.
  localparam logic SPI_CPOL  = 1'b0;
  localparam logic SPI_CPHA  = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  // Chip-select levels (active low).
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;

  // Width of a counter that must hold values 0..n. The extra bit lets the
  // bit counter reach WIDTH itself without wrapping.
  function automatic int cntWidth(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// ---------------------------------------------------------------------------
// spi_controller_if
//   Bundles the frame-request handshake and the SPI pins of one controller.
//   master : the controller's view. It takes start/txData/miso and drives the
//            SPI pins, busy, done and rxData.
//   slave  : the user/peripheral view, which is the mirror image.
//   Signals
//     start   frame request (sampled only while the controller is idle)
//     txData  word to send, latched when start is accepted
//     miso    serial data from the peripheral
//     sclk    SPI clock, idles low
//     cs      chip select, active low
//     mosi    serial data to the peripheral
//     busy    frame in progress
//     done    one-cycle end-of-frame strobe
//     rxData  last received word
// ---------------------------------------------------------------------------
interface spi_controller_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] txData;
  logic             miso;
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rxData;

  modport master (
    input  start, txData, miso,
    output sclk, cs, mosi, busy, done, rxData
  );

  modport slave (
    output start, txData, miso,
    input  sclk, cs, mosi, busy, done, rxData
  );
endinterface

// File: rtl/spi_controller_clk_timer.sv
// ---------------------------------------------------------------------------
// spi_clk_timer
//   Half-period timer for the SPI controller. While enabled, divCnt counts
//   0..CLK_DIV-1 and wraps. phaseEnd is high on the last count of each
//   half-period, which is the cycle in which the controller changes phase.
//   clr restarts the count so that every frame starts phase-aligned.
//   Ports
//     clk      system clock
//     reset    asynchronous, active-high reset
//     clr      restart the count (a frame is being accepted)
//     en       count enable (controller not idle)
//     phaseEnd strobe: the current half-period ends with this cycle
// ---------------------------------------------------------------------------
module spi_clk_timer
  import spi_controller_pkg::*;
#(
  parameter  int CLK_DIV = 4,
  localparam int DIV_W   = cntWidth(CLK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic phaseEnd
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
    end else if (clr) begin
      divCnt <= '0;
    end else if (en) begin
      if (divCnt == DIV_LAST) begin
        divCnt <= '0;
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

  // clr and en never overlap in the controller. The clr term only keeps the
  // strobe clean if a caller ever did assert both.
  assign phaseEnd = en && !clr && (divCnt == DIV_LAST);

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//   SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first. A start pulse while
//   idle runs one full-duplex WIDTH-bit frame. The received word is
//   presented on rxData with a one-cycle done strobe.
//   Frame shape: cs stays low for CLK_DIV*(2*WIDTH+1) cycles, made up of one
//   lead half-period, WIDTH high/low sclk pulses, and a final low half-period
//   that doubles as the trail. A start seen in the done cycle is accepted,
//   so back-to-back frames have cs high for exactly one cycle.
//   Parameters
//     WIDTH    bits per frame (>= 2)
//     CLK_DIV  clk cycles per sclk half-period (>= 1)
//   Ports
//     clk      system clock, all logic on its rising edge
//     reset    asynchronous, active-high reset. It aborts any frame in flight.
//     bus      spi_controller_if.master (start, txData, miso in;
//              sclk, cs, mosi, busy, done, rxData out)
// ---------------------------------------------------------------------------
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  spi_controller_if.master    bus
);

  localparam int               BIT_W    = cntWidth(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

  spiState_t        state;
  spiState_t        stateNext;

  logic             csNext;
  logic             sclkNext;
  logic             mosiNext;
  logic             busyNext;
  logic             doneNext;
  logic [WIDTH-1:0] rxDataNext;

  logic [BIT_W-1:0] bitCnt;
  logic [BIT_W-1:0] bitCntNext;
  logic [BIT_W-1:0] bitInc;

  logic [WIDTH-1:0] txShift;
  logic [WIDTH-1:0] txShiftNext;
  logic [WIDTH-1:0] rxShift;
  logic [WIDTH-1:0] rxShiftNext;

  logic             accept;
  logic             timerEn;
  logic             phaseEnd;

  assign accept  = (state == IDLE) && bus.start;
  assign timerEn = (state != IDLE);
  assign bitInc  = bitCnt + BIT_W'(1);

  spi_clk_timer #(
    .CLK_DIV  (CLK_DIV)
  ) uClkTimer (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (timerEn),
    .phaseEnd (phaseEnd)
  );

  // Next-state and next-output logic. Every output is registered below, so
  // each pin changes on the same edge as the phase it belongs to.
  always_comb begin
    stateNext   = state;
    csNext      = bus.cs;
    sclkNext    = bus.sclk;
    mosiNext    = bus.mosi;
    busyNext    = bus.busy;
    doneNext    = 1'b0;
    rxDataNext  = bus.rxData;
    bitCntNext  = bitCnt;
    txShiftNext = txShift;
    rxShiftNext = rxShift;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          // The word is captured here. Later changes to txData do not
          // affect this frame.
          txShiftNext = bus.txData;
          csNext      = CS_ACTIVE;
          mosiNext    = bus.txData[WIDTH-1];
          bitCntNext  = '0;
          busyNext    = 1'b1;
          stateNext   = LEAD;
        end
      end

      LEAD: begin
        if (phaseEnd) begin
          // First rising edge. miso has been stable since cs fell.
          sclkNext    = ~SPI_CPOL;
          rxShiftNext = {rxShift[WIDTH-2:0], bus.miso};
          stateNext   = HIGH;
        end
      end

      HIGH: begin
        if (phaseEnd) begin
          // Falling edge. Present the next bit unless this was the last one.
          // For the last bit, mosi is held through the trail.
          sclkNext   = SPI_CPOL;
          bitCntNext = bitInc;
          if (bitInc < BIT_LAST) begin
            txShiftNext = txShift << 1;
            mosiNext    = txShift[WIDTH-2];
          end
          stateNext  = LOW;
        end
      end

      LOW: begin
        if (phaseEnd) begin
          if (bitCnt < BIT_LAST) begin
            // Rising edge. The peripheral updated miso at the last falling
            // edge, so it is sampled here only.
            sclkNext    = ~SPI_CPOL;
            rxShiftNext = {rxShift[WIDTH-2:0], bus.miso};
            stateNext   = HIGH;
          end else begin
            // End of the trail: release the bus and publish the word.
            csNext     = CS_IDLE;
            mosiNext   = 1'b0;
            busyNext   = 1'b0;
            doneNext   = 1'b1;
            rxDataNext = rxShift;
            stateNext  = IDLE;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Control and output registers. Reset takes effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bus.cs     <= CS_IDLE;
      bus.sclk   <= SPI_CPOL;
      bus.mosi   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.rxData <= '0;
      bitCnt     <= '0;
    end else begin
      state      <= stateNext;
      bus.cs     <= csNext;
      bus.sclk   <= sclkNext;
      bus.mosi   <= mosiNext;
      bus.busy   <= busyNext;
      bus.done   <= doneNext;
      bus.rxData <= rxDataNext;
      bitCnt     <= bitCntNext;
    end
  end

  // Shift registers carry data only. Every frame reloads txShift and shifts
  // a full WIDTH bits through rxShift before it is used, so stale contents
  // after a reset are never observed.
  always_ff @(posedge clk) begin
    txShift <= txShiftNext;
    rxShift <= rxShiftNext;
  end

endmodule
